// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the MIPS execute stage.
//   - R-type funct codes decoded by the ALU and the mult/div unit
//   - AluOp encodings driven from the decode stage
//   - forwarding-mux select encodings
//   - md_state_t: state of the iterative mult/div unit
//   - magnitude(): absolute value of a 32-bit two's-complement number
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int MD_CYCLES_DEFAULT = 32;

   localparam logic [5:0] FUNCT_SLL  = 6'h00;
   localparam logic [5:0] FUNCT_MFHI = 6'h10;
   localparam logic [5:0] FUNCT_MFLO = 6'h12;
   localparam logic [5:0] FUNCT_MULT = 6'h18;
   localparam logic [5:0] FUNCT_DIV  = 6'h1A;
   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_XOR  = 6'h26;
   localparam logic [5:0] FUNCT_NOR  = 6'h27;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_WB    = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   // The most negative value maps to 2^31, which is still exact as unsigned.
   function automatic logic [31:0] magnitude(input logic [31:0] value);
      return value[31] ? (~value + 32'd1) : value;
   endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ---------------------------------------------------------------------------
// execute_stage_if
// Bundles the ID/EX inputs, forwarding controls and ExMem outputs of the
// execute stage.
//   master: the surrounding pipeline (drives ID/EX fields, forwarding
//           selects and writeback data; observes ExMem* and ExStall)
//   slave : the execute stage itself
// ---------------------------------------------------------------------------
interface execute_stage_if;

   logic [31:0] IdExReadData1;
   logic [31:0] IdExReadData2;
   logic [31:0] IdExImm;
   logic [4:0]  IdExShamt;
   logic [5:0]  IdExFunct;
   logic [4:0]  IdExRt;
   logic [4:0]  IdExRd;
   logic        IdExRegDst;
   logic        IdExAluSrc;
   logic [1:0]  IdExAluOp;
   logic        IdExwriteMemoryEnable;
   logic        IdExreadMemoryEnable;
   logic        IdExwriteRegEnable;
   logic        IdExwritebackRegCtrl;
   logic [1:0]  ForwardA;
   logic [1:0]  ForwardB;
   logic [31:0] WbWriteData;

   logic        ExStall;
   logic [31:0] ExMemAluOutput;
   logic [31:0] ExMemReadData2;
   logic [4:0]  ExMemDestination_Rt_RdOutput;
   logic [1:0]  ExMemAluOp;
   logic        writeMemoryEnable;
   logic        readMemoryEnable;
   logic        ExMemwriteRegEnable;
   logic        ExMemwritebackRegCtrl;

   modport master (
      output IdExReadData1, IdExReadData2, IdExImm, IdExShamt, IdExFunct,
             IdExRt, IdExRd, IdExRegDst, IdExAluSrc, IdExAluOp,
             IdExwriteMemoryEnable, IdExreadMemoryEnable,
             IdExwriteRegEnable, IdExwritebackRegCtrl,
             ForwardA, ForwardB, WbWriteData,
      input  ExStall, ExMemAluOutput, ExMemReadData2,
             ExMemDestination_Rt_RdOutput, ExMemAluOp,
             writeMemoryEnable, readMemoryEnable,
             ExMemwriteRegEnable, ExMemwritebackRegCtrl
   );

   modport slave (
      input  IdExReadData1, IdExReadData2, IdExImm, IdExShamt, IdExFunct,
             IdExRt, IdExRd, IdExRegDst, IdExAluSrc, IdExAluOp,
             IdExwriteMemoryEnable, IdExreadMemoryEnable,
             IdExwriteRegEnable, IdExwritebackRegCtrl,
             ForwardA, ForwardB, WbWriteData,
      output ExStall, ExMemAluOutput, ExMemReadData2,
             ExMemDestination_Rt_RdOutput, ExMemAluOp,
             writeMemoryEnable, readMemoryEnable,
             ExMemwriteRegEnable, ExMemwritebackRegCtrl
   );

endinterface

// File: rtl/execute_stage_muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative signed multiply/divide with HI/LO registers.
//   clk, rst     : clock, synchronous active-high reset (aborts any operation)
//   start        : a mult/div is present in EX
//   is_div       : 1 = div, 0 = mult (sampled with start)
//   op_a, op_b   : forwarded rs / rt, latched on issue
//   stall        : hold the front end
//   retire       : last iteration cycle; HI/LO are written at its end
//   hi, lo       : HI/LO register contents
// Both operations run on magnitudes for MD_CYCLES iterations (one bit per
// cycle) and the signs are corrected when HI/LO are written.
// ---------------------------------------------------------------------------
module muldiv_unit
   import mips_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_div,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            stall,
   output logic            retire,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(MD_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

   md_state_t state, state_next;
   logic [CW-1:0] count, count_next;

   logic [2*XLEN-1:0] acc, acc_next;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN-1:0]   orig_a;
   logic              div_q, neg_a, neg_b;
   logic              issue;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_shifted;
   logic [XLEN-1:0]   rem_new;
   logic [2*XLEN-1:0] product;
   logic [XLEN-1:0]   quot_fix, rem_fix;
   logic [XLEN-1:0]   hi_next, lo_next;

   // State register and iteration counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // Next state: leave IDLE on a new mult/div, return after the last iteration.
   always_comb begin
      state_next = state;
      count_next = count;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = BUSY;
               count_next = '0;
            end
         end
         BUSY: begin
            if (count == LAST) begin
               state_next = IDLE;
               count_next = '0;
            end else begin
               count_next = count + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            count_next = '0;
         end
      endcase
   end

   assign issue  = (state == IDLE) && start;
   assign retire = (state == BUSY) && (count == LAST);
   assign stall  = issue || ((state == BUSY) && (count != LAST));

   // One iteration. Multiply: shift-add with the multiplier in the low half
   // of acc. Divide: restoring, remainder in the high half and quotient bits
   // shifting into the low half. The dividend's top magnitude bit can reach
   // acc's MSB only transiently, so the trial compare uses XLEN+1 bits.
   always_comb begin
      mul_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
      rem_shifted = acc[2*XLEN-1:XLEN-1];
      rem_new     = rem_shifted[XLEN-1:0] - mag_b;
      if (div_q) begin
         if (rem_shifted >= {1'b0, mag_b}) begin
            acc_next = {rem_new, acc[XLEN-2:0], 1'b1};
         end else begin
            acc_next = {acc[2*XLEN-2:0], 1'b0};
         end
      end else begin
         acc_next = {mul_sum, acc[XLEN-1:1]};
      end
   end

   // Sign correction applied to the final iteration's result.
   always_comb begin
      product  = (neg_a ^ neg_b) ? (~acc_next + 1'b1) : acc_next;
      quot_fix = (neg_a ^ neg_b) ? (~acc_next[XLEN-1:0] + 1'b1) : acc_next[XLEN-1:0];
      rem_fix  = neg_a ? (~acc_next[2*XLEN-1:XLEN] + 1'b1) : acc_next[2*XLEN-1:XLEN];
      if (!div_q) begin
         hi_next = product[2*XLEN-1:XLEN];
         lo_next = product[XLEN-1:0];
      end else if (mag_b == '0) begin
         hi_next = orig_a;
         lo_next = '1;
      end else begin
         hi_next = rem_fix;
         lo_next = quot_fix;
      end
   end

   // Operand latch on issue, iteration while busy, HI/LO write on retire.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         mag_b  <= '0;
         orig_a <= '0;
         div_q  <= 1'b0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else if (issue) begin
         acc    <= {{XLEN{1'b0}}, magnitude(op_a)};
         mag_b  <= magnitude(op_b);
         orig_a <= op_a;
         div_q  <= is_div;
         neg_a  <= op_a[XLEN-1];
         neg_b  <= op_b[XLEN-1];
      end else if (state == BUSY) begin
         acc <= acc_next;
         if (retire) begin
            hi <= hi_next;
            lo <= lo_next;
         end
      end
   end

endmodule

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// EX stage of the 5-stage MIPS pipeline.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : execute_stage_if.slave -- ID/EX fields, ForwardA/B, WbWriteData in;
//         ExStall and the registered ExMem* outputs out
// Contains the forwarding muxes, single-cycle ALU, destination select, the
// ExMem register and the iterative mult/div unit.
// ---------------------------------------------------------------------------
module execute_stage
   import mips_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   execute_stage_if.slave   bus
);

   logic [XLEN-1:0] op_a, fwd_b, op_b, alu_result;
   logic [XLEN-1:0] hi, lo;
   logic [4:0]      dest;
   logic            md_start, md_stall, md_retire, bubble;

   // Forwarding muxes; select 11 falls back to the register value.
   always_comb begin
      case (bus.ForwardA)
         FWD_EXMEM: op_a = bus.ExMemAluOutput;
         FWD_WB:    op_a = bus.WbWriteData;
         default:   op_a = bus.IdExReadData1;
      endcase
      case (bus.ForwardB)
         FWD_EXMEM: fwd_b = bus.ExMemAluOutput;
         FWD_WB:    fwd_b = bus.WbWriteData;
         default:   fwd_b = bus.IdExReadData2;
      endcase
      op_b = bus.IdExAluSrc ? bus.IdExImm : fwd_b;
   end

   // ALU; mult/div produce 0 here, their results come back through mfhi/mflo.
   always_comb begin
      alu_result = '0;
      case (bus.IdExAluOp)
         ALUOP_ADD: alu_result = op_a + op_b;
         ALUOP_SUB: alu_result = op_a - op_b;
         ALUOP_RTYPE: begin
            case (bus.IdExFunct)
               FUNCT_SLL:  alu_result = op_b << bus.IdExShamt;
               FUNCT_ADD,
               FUNCT_ADDU: alu_result = op_a + op_b;
               FUNCT_SUB:  alu_result = op_a - op_b;
               FUNCT_AND:  alu_result = op_a & op_b;
               FUNCT_OR:   alu_result = op_a | op_b;
               FUNCT_XOR:  alu_result = op_a ^ op_b;
               FUNCT_NOR:  alu_result = ~(op_a | op_b);
               FUNCT_SLT:  alu_result = ($signed(op_a) < $signed(op_b)) ? 1 : 0;
               FUNCT_MFHI: alu_result = hi;
               FUNCT_MFLO: alu_result = lo;
               default:    alu_result = '0;
            endcase
         end
         default: alu_result = '0;
      endcase
   end

   assign dest     = bus.IdExRegDst ? bus.IdExRd : bus.IdExRt;
   assign md_start = (bus.IdExAluOp == ALUOP_RTYPE) &&
                     ((bus.IdExFunct == FUNCT_MULT) || (bus.IdExFunct == FUNCT_DIV));

   muldiv_unit #(
      .XLEN      (XLEN),
      .MD_CYCLES (MD_CYCLES)
   ) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (md_start),
      .is_div (bus.IdExFunct == FUNCT_DIV),
      .op_a   (op_a),
      .op_b   (fwd_b),
      .stall  (md_stall),
      .retire (md_retire),
      .hi     (hi),
      .lo     (lo)
   );

   assign bus.ExStall = md_stall;

   // The retire cycle is not a stall but the mult/div itself must not reach
   // MEM, so it is squashed along with every stalled cycle.
   assign bubble = md_stall || md_retire;

   // ExMem pipeline register.
   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         bus.ExMemAluOutput               <= '0;
         bus.ExMemReadData2               <= '0;
         bus.ExMemDestination_Rt_RdOutput <= '0;
         bus.ExMemAluOp                   <= '0;
         bus.writeMemoryEnable            <= 1'b0;
         bus.readMemoryEnable             <= 1'b0;
         bus.ExMemwriteRegEnable          <= 1'b0;
         bus.ExMemwritebackRegCtrl        <= 1'b0;
      end else begin
         bus.ExMemAluOutput               <= alu_result;
         bus.ExMemReadData2               <= fwd_b;
         bus.ExMemDestination_Rt_RdOutput <= dest;
         bus.ExMemAluOp                   <= bus.IdExAluOp;
         bus.writeMemoryEnable            <= bus.IdExwriteMemoryEnable;
         bus.readMemoryEnable             <= bus.IdExreadMemoryEnable;
         bus.ExMemwriteRegEnable          <= bus.IdExwriteRegEnable;
         bus.ExMemwritebackRegCtrl        <= bus.IdExwritebackRegCtrl;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
// Self-checking bench for execute_stage. Expected ExMem contents are queued
// when an instruction is driven and compared after the following clock edge.
// ---------------------------------------------------------------------------
module tb_execute_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   logic [31:0] model_hi = 32'd0;
   logic [31:0] model_lo = 32'd0;

   always #5 clk = ~clk;

   execute_stage_if bus ();

   execute_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] rs, rt, imm, wb_data;
      logic [4:0]  shamt, rt_addr, rd_addr;
      logic [5:0]  funct;
      logic        reg_dst, alu_src, wr_mem, rd_mem, wr_reg, wb_ctl;
      logic [1:0]  alu_op, fa, fb;
   } ins_t;

   typedef struct {
      string       tag;
      logic [31:0] alu, rd2;
      logic [4:0]  dest;
      logic [3:0]  ctl;
      logic [1:0]  alu_op;
   } exp_t;

   exp_t sb[$];

   // Count one comparison and report it when it does not match.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic ins_t nopIns();
      ins_t i;
      i.rs = 0; i.rt = 0; i.imm = 0; i.wb_data = 0;
      i.shamt = 0; i.rt_addr = 0; i.rd_addr = 0; i.funct = 0;
      i.reg_dst = 0; i.alu_src = 0; i.wr_mem = 0; i.rd_mem = 0;
      i.wr_reg = 0; i.wb_ctl = 0; i.alu_op = 0; i.fa = 0; i.fb = 0;
      return i;
   endfunction

   function automatic ins_t rIns(input logic [5:0] funct, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [4:0] rd);
      ins_t i = nopIns();
      i.alu_op = 2'b10; i.funct = funct; i.rs = rs; i.rt = rt;
      i.reg_dst = 1; i.rd_addr = rd; i.rt_addr = 5'd2; i.wr_reg = 1;
      return i;
   endfunction

   task automatic driveIns(input ins_t i);
      bus.IdExReadData1 = i.rs;        bus.IdExReadData2 = i.rt;
      bus.IdExImm = i.imm;             bus.IdExShamt = i.shamt;
      bus.IdExFunct = i.funct;         bus.IdExRt = i.rt_addr;
      bus.IdExRd = i.rd_addr;          bus.IdExRegDst = i.reg_dst;
      bus.IdExAluSrc = i.alu_src;      bus.IdExAluOp = i.alu_op;
      bus.IdExwriteMemoryEnable = i.wr_mem;
      bus.IdExreadMemoryEnable = i.rd_mem;
      bus.IdExwriteRegEnable = i.wr_reg;
      bus.IdExwritebackRegCtrl = i.wb_ctl;
      bus.ForwardA = i.fa;             bus.ForwardB = i.fb;
      bus.WbWriteData = i.wb_data;
   endtask

   // Drive one single-cycle instruction and queue what ExMem must hold next.
   task automatic applyStimulus(input string tag, input ins_t i,
                                input logic [31:0] exp_alu, input logic [31:0] exp_rd2);
      exp_t e;
      @(negedge clk);
      driveIns(i);
      e.tag = tag;
      e.alu = exp_alu;
      e.rd2 = exp_rd2;
      e.dest = i.reg_dst ? i.rd_addr : i.rt_addr;
      e.ctl = {i.wr_mem, i.rd_mem, i.wr_reg, i.wb_ctl};
      e.alu_op = i.alu_op;
      sb.push_back(e);
      #1 checkOutput({tag, ":stall"}, {31'd0, bus.ExStall}, 32'd0);
   endtask

   // Scoreboard consumer: compare ExMem after each edge that has a pending entry.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput({e.tag, ":alu"}, bus.ExMemAluOutput, e.alu);
         checkOutput({e.tag, ":rd2"}, bus.ExMemReadData2, e.rd2);
         checkOutput({e.tag, ":dest"}, {27'd0, bus.ExMemDestination_Rt_RdOutput}, {27'd0, e.dest});
         checkOutput({e.tag, ":ctl"}, {28'd0, bus.writeMemoryEnable, bus.readMemoryEnable,
                     bus.ExMemwriteRegEnable, bus.ExMemwritebackRegCtrl}, {28'd0, e.ctl});
         checkOutput({e.tag, ":aluop"}, {30'd0, bus.ExMemAluOp}, {30'd0, e.alu_op});
      end
   end

   // Reference results using the simulator's own signed arithmetic.
   task automatic mdModel(input logic [31:0] a, input logic [31:0] b, input bit is_div);
      longint p;
      int sa, sb_v;
      sa = int'(a);
      sb_v = int'(b);
      if (!is_div) begin
         p = longint'(sa) * longint'(sb_v);
         model_hi = p[63:32];
         model_lo = p[31:0];
      end else if (sb_v == 0) begin
         model_hi = a;
         model_lo = 32'hFFFF_FFFF;
      end else begin
         model_lo = sa / sb_v;
         model_hi = sa % sb_v;
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ":stall"}, {31'd0, bus.ExStall}, 32'd0);
      checkOutput({tag, ":alu"}, bus.ExMemAluOutput, 32'd0);
      checkOutput({tag, ":rd2"}, bus.ExMemReadData2, 32'd0);
      checkOutput({tag, ":dest"}, {27'd0, bus.ExMemDestination_Rt_RdOutput}, 32'd0);
      checkOutput({tag, ":aluop"}, {30'd0, bus.ExMemAluOp}, 32'd0);
      checkOutput({tag, ":ctl"}, {28'd0, bus.writeMemoryEnable, bus.readMemoryEnable,
                  bus.ExMemwriteRegEnable, bus.ExMemwritebackRegCtrl}, 32'd0);
   endtask

   // Issue a mult/div, count stall cycles, check the bubbles, then read HI/LO.
   task automatic runMd(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit is_div);
      ins_t i;
      int stalls;
      i = rIns(is_div ? 6'h1A : 6'h18, a, b, 5'd7);
      @(negedge clk);
      driveIns(i);
      #1;
      stalls = 0;
      while (bus.ExStall && stalls < 100) begin
         stalls++;
         @(posedge clk);
         #1;
         checkOutput({tag, ":bubble_we"}, {31'd0, bus.ExMemwriteRegEnable}, 32'd0);
         checkOutput({tag, ":bubble_alu"}, bus.ExMemAluOutput, 32'd0);
         if (stalls == 1) begin
            // Forwarding changes after issue must not disturb the latched operands.
            bus.ForwardA = 2'b10;
            bus.ForwardB = 2'b10;
            bus.WbWriteData = 32'h5555_AAAA;
         end
      end
      checkOutput({tag, ":stall_cycles"}, stalls, 32);
      @(posedge clk);
      #1;
      checkOutput({tag, ":retire_we"}, {31'd0, bus.ExMemwriteRegEnable}, 32'd0);
      mdModel(a, b, is_div);
      applyStimulus({tag, ":mflo"}, rIns(6'h12, 0, 0, 5'd8), model_lo, 32'd0);
      applyStimulus({tag, ":mfhi"}, rIns(6'h10, 0, 0, 5'd9), model_hi, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      ins_t i;
      driveIns(nopIns());
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 checkAllZero("reset");
      @(negedge clk);
      rst = 1'b0;

      applyStimulus("mflo_rst", rIns(6'h12, 0, 0, 5'd8), 32'd0, 32'd0);
      applyStimulus("mfhi_rst", rIns(6'h10, 0, 0, 5'd8), 32'd0, 32'd0);

      i = nopIns(); i.imm = 32'd100; i.alu_src = 1; i.rt = 32'h11;
      i.rt_addr = 5'd4; i.wr_reg = 1;
      applyStimulus("addi", i, 32'd100, 32'h11);

      i = rIns(6'h20, 32'd5, 32'd7, 5'd9); i.fa = 2'b01;
      applyStimulus("add_fwdA", i, 32'd107, 32'd7);

      i = nopIns(); i.rs = 32'h40; i.imm = 32'd8; i.alu_src = 1; i.fb = 2'b10;
      i.wb_data = 32'hDEAD; i.rt = 32'h1234; i.rt_addr = 5'd3; i.wr_mem = 1;
      applyStimulus("sw", i, 32'h48, 32'hDEAD);

      i = nopIns(); i.rs = 32'h100; i.imm = 32'hFFFF_FFFC; i.alu_src = 1;
      i.rt = 32'h77; i.rt_addr = 5'd5; i.rd_mem = 1; i.wr_reg = 1; i.wb_ctl = 1;
      applyStimulus("lw", i, 32'hFC, 32'h77);

      i = nopIns(); i.alu_op = 2'b01; i.rs = 32'd10; i.rt = 32'd3; i.rt_addr = 5'd6;
      applyStimulus("aluop_sub", i, 32'd7, 32'd3);

      applyStimulus("sub", rIns(6'h22, 32'd3, 32'd10, 5'd1), 32'hFFFF_FFF9, 32'd10);
      applyStimulus("and", rIns(6'h24, 32'hF0F0, 32'hFF00, 5'd1), 32'hF000, 32'hFF00);
      applyStimulus("or",  rIns(6'h25, 32'hF0F0, 32'hFF00, 5'd1), 32'hFFF0, 32'hFF00);
      applyStimulus("xor", rIns(6'h26, 32'hF0F0, 32'hFF00, 5'd1), 32'h0FF0, 32'hFF00);
      applyStimulus("nor", rIns(6'h27, 32'hF0F0, 32'hFF00, 5'd1), 32'hFFFF_000F, 32'hFF00);
      applyStimulus("slt_neg", rIns(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd1), 32'd1, 32'd1);
      applyStimulus("slt_pos", rIns(6'h2A, 32'd5, 32'hFFFF_FFFD, 5'd1), 32'd0, 32'hFFFF_FFFD);
      i = rIns(6'h00, 32'd0, 32'd3, 5'd1); i.shamt = 5'd4;
      applyStimulus("sll", i, 32'h30, 32'd3);
      applyStimulus("unknown", rIns(6'h3F, 32'd5, 32'd6, 5'd1), 32'd0, 32'd6);
      applyStimulus("addu_wrap", rIns(6'h21, 32'hFFFF_FFFF, 32'd2, 5'd1), 32'd1, 32'd2);
      i = rIns(6'h20, 32'd5, 32'd1, 5'd1); i.fa = 2'b11;
      applyStimulus("fwd11", i, 32'd6, 32'd1);
      i = rIns(6'h20, 32'd1, 32'd100, 5'd1); i.fb = 2'b01;
      applyStimulus("fwdB_exmem", i, 32'd7, 32'd6);

      runMd("mult_neg", 32'hFFFF_FFF9, 32'd3, 1'b0);
      runMd("mult_big", 32'h1234_5678, 32'hFFFF_F000, 1'b0);
      runMd("div_neg", 32'hFFFF_FFF9, 32'd2, 1'b1);
      runMd("div_mixed", 32'd100, 32'hFFFF_FFF9, 1'b1);
      runMd("div_zero", 32'd9, 32'd0, 1'b1);

      // Reset while a mult is at count 10: the op is dropped and HI/LO clear.
      @(negedge clk);
      driveIns(rIns(6'h18, 32'd6, 32'd7, 5'd7));
      repeat (11) @(posedge clk);
      #1;
      rst = 1'b1;
      driveIns(nopIns());
      @(posedge clk);
      #1 checkAllZero("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      applyStimulus("rst_mid:mflo", rIns(6'h12, 0, 0, 5'd8), 32'd0, 32'd0);
      applyStimulus("rst_mid:mfhi", rIns(6'h10, 0, 0, 5'd8), 32'd0, 32'd0);

      @(negedge clk);
      driveIns(nopIns());
      repeat (2) @(posedge clk);
      #2;
      checkOutput("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
